// File: rtl/xs3_to_bcd_deser_if.sv
// Digit-link and word-output handshake bundle for the Excess-3 to BCD deserializer.
interface xs3_to_bcd_deser_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_xs3;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bcd;
  logic [3:0]   out_ndig;
  logic         out_err;

  // Digit source and word consumer side
  modport master (
    output in_valid, in_xs3, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndig, out_err
  );

  // Deserializer side
  modport slave (
    input  in_valid, in_xs3, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_ndig, out_err
  );
endinterface

// File: rtl/xs3_to_bcd_deser.sv
// Digit-serial Excess-3 to packed-BCD deserializer: collects up to DIGITS digits,
// MSD first, into a right-justified BCD word presented on a valid/ready output.
module xs3_to_bcd_deser #(
  parameter int unsigned DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  xs3_to_bcd_deser_if.slave bus
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0] ndig_q, ndig_d;
  logic             oerr_q, oerr_d;

  logic             accept;
  logic             consume;
  logic             dig_bad;
  logic [3:0]       dig_dec;
  logic [W-1:0]     acc_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_nxt;
  logic             word_close;

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  // Per-digit decode; illegal codes yield zero and flag the word
  assign dig_bad = (bus.in_xs3 < 4'd3) || (bus.in_xs3 > 4'd12);
  assign dig_dec = dig_bad ? 4'd0 : (bus.in_xs3 - 4'd3);

  // Truncating the concatenation drops the oldest nibble and keeps DIGITS=1 legal
  assign acc_nxt    = W'({acc_q, dig_dec});
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign err_nxt    = err_q | dig_bad;
  assign word_close = bus.in_last || (cnt_inc == CNT_W'(DIGITS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    oerr_d  = oerr_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_nxt;
          cnt_d = cnt_inc;
          err_d = err_nxt;
          if (word_close) begin
            state_d = HOLD;
            bcd_d   = acc_nxt;
            ndig_d  = cnt_inc;
            oerr_d  = err_nxt;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bcd_q       <= '0;
      ndig_q      <= '0;
      oerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      bcd_q       <= bcd_d;
      ndig_q      <= ndig_d;
      oerr_q      <= oerr_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = bcd_q;
  assign bus.out_ndig  = ndig_q;
  assign bus.out_err   = oerr_q;

endmodule

// File: doc/xs3_to_bcd_deser.md
# xs3_to_bcd_deser

Digit-serial Excess-3 to packed-BCD decoder. Accepts one Excess-3 digit per handshake, most significant digit first, and subtracts 3 from each to recover the BCD digit. It assembles up to DIGITS digits into a right-justified packed BCD word and presents that word on a valid/ready output with a digit count and an invalid-code flag. It sits on the receive side of the Excess-3 digit link, upstream of the BCD display and arithmetic logic.

## Interface
- DIGITS, 4, maximum digits per word; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_xs3/in_last are valid this cycle.
- in_ready  out  1  block can accept a digit this cycle.
- in_xs3  in  4  Excess-3 digit code.
- in_last  in  1  marks the final digit of the current word.
- out_valid  out  1  out_bcd/out_ndig/out_err hold a complete word.
- out_ready  in  1  consumer accepts the word.
- out_bcd  out  4*DIGITS  packed BCD word; digit 0 in bits [3:0]; right-justified.
- out_ndig  out  4  number of digits received in the word, 1..DIGITS.
- out_err  out  1  at least one digit of the word was an illegal code.

## Operation
- Transfers:
  - A digit is accepted when in_valid && in_ready at a rising edge.
  - A word is consumed when out_valid && out_ready at a rising edge.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Per-digit decode:
  - Legal codes are 4'h3..4'hC. A legal code decodes to in_xs3 - 3 (4-bit), giving 0..9.
  - Illegal codes (0..2, 13..15) decode to 4'h0 and set a sticky word error bit.
- Accumulation:
  - On accept: accumulator <= {accumulator[4*DIGITS-5:0], decoded}. Digit count increments. Error bit ORs in the digit's illegal flag.
  - Upper digits of a short word remain 0, so the word is right-justified.
- Word close: occurs on the accepted digit that has in_last=1 or that brings the count to DIGITS, whichever comes first.
  - Next state is HOLD.
  - out_bcd, out_ndig and out_err load from the accumulator including the closing digit.
  - in_last is ignored on any digit other than the closing one. A word that reaches DIGITS closes even when in_last=0.
- HOLD:
  - out_bcd, out_ndig and out_err stay constant until consumed.
  - in_valid is ignored; no digit is accepted.
  - On consume: next state is ACCUM, and the accumulator, count and error bit clear.
  - out_bcd, out_ndig and out_err keep their last value after the consume; only out_valid drops.
- Decode is pure arithmetic. No carry or interaction between digits.

## Timing
- Reset (rst_n low, asynchronous):
  - state=ACCUM, in_ready=0, out_valid=0, out_bcd=0, out_ndig=0, out_err=0.
  - Accumulator, count and error bit clear.
- in_ready is registered. It rises on the first rising edge after rst_n deasserts, and afterwards equals (state==ACCUM).
- Latency: out_valid rises 1 cycle after the edge that accepts the closing digit, and out_bcd is valid in that same cycle.
- out_valid falls on the edge after the consuming edge. in_ready rises at that same edge.
- First digit of the next word is accepted no earlier than 1 cycle after the consume.
- Throughput: max one DIGITS-digit word per DIGITS+1 cycles.
- Source stalls (in_valid gaps) are allowed at any point mid-word; accumulator state is held.
- out_ready may be held high continuously; each word is then consumed in its first out_valid cycle.
- rst_n asserted mid-word or in HOLD: the partial or held word is discarded with no output. After release, the block restarts at digit 0.
- No combinational path from any input to any output.

## Test plan
- Full word: in_xs3 4'h4,4'h5,4'h6,4'h7, in_last on the 4th digit, out_ready=1 -> one cycle later out_valid=1, out_bcd=16'h1234, out_ndig=4, out_err=0. out_valid drops the next cycle.
- Short word: in_xs3 4'hC then 4'h3 with in_last=1 -> out_bcd=16'h0090, out_ndig=2, out_err=0.
- Illegal codes: in_xs3 4'h4,4'h0,4'h5,4'hF -> out_bcd=16'h1020, out_ndig=4, out_err=1.
  - The following word 4'h3,4'h3,4'h3,4'h3 -> out_bcd=16'h0000, out_err=0 (error bit clears between words).
- Backpressure: complete a word with out_ready=0 for 5 cycles while in_valid=1 with 4'h9 -> in_ready=0 and outputs constant for all 5 cycles.
  - Raise out_ready -> consumed. Next word begins with the digit presented 1 cycle later.
- Reset mid-operation: accept 4'h7,4'h8, then pulse rst_n low between edges -> out_valid, in_ready and out_bcd read 0 immediately.
  - After release, send 4'h3,4'h3,4'h3,4'hC -> out_bcd=16'h0009 with no trace of the discarded digits.
- No in_last and source gaps: 4 digits 4'h8,4'h9,4'hA,4'hB with in_last=0 and in_valid toggling 1-0 -> word closes on the 4th accepted digit, out_bcd=16'h5678, out_ndig=4.
